spi_xfer_sequencer: RTL and testbench

// - Master-mode SPI transfer sequencer. Double-buffers one CPU-written byte, drives SCK/MOSI/SS_n with a programmable baud rate and samples MISO.
// - Emits the single-cycle SPTEF, SPIF and MODF event pulses consumed by the SPI status/interrupt flag register.
// - Sits between the CPU register interface (SPIDR write/read) and the SPI pins.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_xfer_sequencer_if.sv | 32 +++
 rtl/spi_baud_gen.sv | 38 +++
 rtl/spi_xfer_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI master transfer sequencer.
// Both the sequencer and its bus interface import this package.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DIV_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    XFER,
    DONE,
    GAP
  } state_e;

  // Edge counter must hold 2*data_w itself, so one bit more than log2.
  function automatic int unsigned edge_cnt_w(input int unsigned data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// CPU-side byte handshake and SPI pin bundle of the transfer sequencer.
// The master modport is the sequencer; the slave modport is whatever drives it.
interface spi_xfer_sequencer_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              tx_wr;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              sptef_set;
  logic              spif_set;
  logic              modf_set;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic              ss_n;
  logic              ss_in_n;

  modport master (
    input  tx_wr, tx_data, miso, ss_in_n,
    output rx_data, busy, sptef_set, spif_set, modf_set, sck, mosi, ss_n
  );

  modport slave (
    output tx_wr, tx_data, miso, ss_in_n,
    input  rx_data, busy, sptef_set, spif_set, modf_set, sck, mosi, ss_n
  );

endinterface

// File: rtl/spi_baud_gen.sv
// Half-period down-counter: tick fires on the enabled cycle where the count is
// zero, and the counter reloads from div on that same cycle.
module spi_baud_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // NOTE: every output of an always_comb gets a default first; a path that leaves one unassigned infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (load) begin
      cnt_d = div;
    end else if (en) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = div;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
  end

  // NOTE: flops use <= so every register updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Master-mode SPI transfer sequencer: one-byte tx buffer, shifters, SCK/SS_n
// generation and SPTEF/SPIF/MODF event pulses. All outputs are registered.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spe,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsbfe,
  input  logic [DIV_W-1:0]     baud_div,
  spi_xfer_sequencer_if.master bus
);

  localparam int unsigned    ECW   = edge_cnt_w(DATA_W);
  localparam logic [ECW-1:0] EDGES = ECW'(2 * DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d, shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0] shift_rx_q, shift_rx_d, rx_data_q, rx_data_d;
  logic [ECW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tx_full_q, tx_full_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsbfe_q, lsbfe_d;
  logic              sck_q, sck_d, mosi_q, mosi_d, ss_n_q, ss_n_d, busy_q, busy_d;
  logic              sptef_q, sptef_d, spif_q, spif_d, modf_q, modf_d;
  logic              modf_armed_q, modf_armed_d;
  logic              wr_acc, modf_evt, tick, do_sample, do_shift;

  // A fault fires once per low excursion of ss_in_n.
  assign modf_evt  = spe & ~bus.ss_in_n & modf_armed_q;
  assign wr_acc    = bus.tx_wr & spe & (~tx_full_q | (state_q == LOAD));
  // Edge k = edge_cnt_q+1; odd edges sample when cpha=0, even ones when cpha=1.
  assign do_sample = ~edge_cnt_q[0] ^ cpha_q;
  assign do_shift  = ~do_sample & (edge_cnt_q != '0) & (edge_cnt_q != EDGES - ECW'(1));

  spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .load ((state_q == LOAD) | (state_q == DONE)),
    .en   ((state_q == XFER) | (state_q == GAP)),
    .div  ((state_q == LOAD) ? baud_div : div_q),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    tx_buf_d     = tx_buf_q;
    tx_full_d    = tx_full_q;
    shift_tx_d   = shift_tx_q;
    shift_rx_d   = shift_rx_q;
    rx_data_d    = rx_data_q;
    edge_cnt_d   = edge_cnt_q;
    div_d        = div_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    lsbfe_d      = lsbfe_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    ss_n_d       = ss_n_q;
    sptef_d      = 1'b0;
    spif_d       = 1'b0;
    modf_armed_d = bus.ss_in_n | (modf_armed_q & ~modf_evt);

    unique case (state_q)
      IDLE: begin
        sck_d  = cpol;
        ss_n_d = 1'b1;
        if (tx_full_q | wr_acc) state_d = LOAD;
      end
      LOAD: begin
        shift_tx_d = tx_buf_q;
        shift_rx_d = '0;
        tx_full_d  = 1'b0;
        sptef_d    = 1'b1;
        ss_n_d     = 1'b0;
        mosi_d     = lsbfe ? tx_buf_q[0] : tx_buf_q[DATA_W-1];
        cpol_d     = cpol;
        cpha_d     = cpha;
        lsbfe_d    = lsbfe;
        div_d      = baud_div;
        sck_d      = cpol;
        edge_cnt_d = '0;
        state_d    = XFER;
      end
      XFER: begin
        if (tick) begin
          if (edge_cnt_q == EDGES) begin
            state_d = DONE;
          end else begin
            sck_d      = ~sck_q;
            edge_cnt_d = edge_cnt_q + ECW'(1);
            if (do_sample) begin
              shift_rx_d = lsbfe_q ? {bus.miso, shift_rx_q[DATA_W-1:1]}
                                   : {shift_rx_q[DATA_W-2:0], bus.miso};
            end
            if (do_shift) begin
              shift_tx_d = lsbfe_q ? (shift_tx_q >> 1) : (shift_tx_q << 1);
              mosi_d     = lsbfe_q ? shift_tx_q[1] : shift_tx_q[DATA_W-2];
            end
          end
        end
      end
      DONE: begin
        rx_data_d = shift_rx_q;
        spif_d    = 1'b1;
        ss_n_d    = 1'b1;
        sck_d     = cpol_q;
        state_d   = GAP;
      end
      GAP: begin
        sck_d  = cpol_q;
        ss_n_d = 1'b1;
        if (tick) state_d = (tx_full_q | wr_acc) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_acc) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    // Mode fault and spe=0 share one abort path; only the fault raises modf_set.
    if (!spe || modf_evt) begin
      state_d   = IDLE;
      ss_n_d    = 1'b1;
      sck_d     = cpol;
      tx_full_d = 1'b0;
      spif_d    = 1'b0;
    end
    modf_d = modf_evt;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_buf_q     <= '0;
      tx_full_q    <= 1'b0;
      shift_tx_q   <= '0;
      shift_rx_q   <= '0;
      rx_data_q    <= '0;
      edge_cnt_q   <= '0;
      div_q        <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsbfe_q      <= 1'b0;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      ss_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      sptef_q      <= 1'b0;
      spif_q       <= 1'b0;
      modf_q       <= 1'b0;
      modf_armed_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tx_buf_q     <= tx_buf_d;
      tx_full_q    <= tx_full_d;
      shift_tx_q   <= shift_tx_d;
      shift_rx_q   <= shift_rx_d;
      rx_data_q    <= rx_data_d;
      edge_cnt_q   <= edge_cnt_d;
      div_q        <= div_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      lsbfe_q      <= lsbfe_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      ss_n_q       <= ss_n_d;
      busy_q       <= busy_d;
      sptef_q      <= sptef_d;
      spif_q       <= spif_d;
      modf_q       <= modf_d;
      modf_armed_q <= modf_armed_d;
    end
  end

  assign bus.sck       = sck_q;
  assign bus.mosi      = mosi_q;
  assign bus.ss_n      = ss_n_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.busy      = busy_q;
  assign bus.sptef_set = sptef_q;
  assign bus.spif_set  = spif_q;
  assign bus.modf_set  = modf_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: a table of single-frame vectors plus
// hand-written sequences for queuing, buffer overflow, mode fault, spe abort and reset.
module tb_spi_xfer_sequencer;

  logic       clk = 1'b0;
  logic       rst, spe, cpol, cpha, lsbfe;
  logic [7:0] baud_div;
  logic       loop_en;
  logic [7:0] m_pat;
  logic       model_bit;

  spi_xfer_sequencer_if #(.DATA_W(8)) bus ();

  spi_xfer_sequencer #(.DATA_W(8), .DIV_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .spe      (spe),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsbfe    (lsbfe),
    .baud_div (baud_div),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: presents m_pat in the configured bit order and advances on
  // its launch edges (even edges for cpha=0, odd edges after the first for cpha=1).
  int   m_edge = 0;
  int   m_idx  = 0;
  logic m_prev_sck = 1'b0;
  always @(bus.sck or bus.ss_n) begin
    if (bus.ss_n) begin
      m_edge = 0;
      m_idx  = 0;
    end else if (bus.sck != m_prev_sck) begin
      m_edge++;
      if (cpha ? (m_edge[0] && m_edge > 1) : !m_edge[0]) m_idx++;
    end
    m_prev_sck = bus.sck;
  end
  assign model_bit = (m_idx < 8) ? (lsbfe ? m_pat[m_idx[2:0]] : m_pat[3'd7 - m_idx[2:0]]) : 1'b0;
  assign bus.miso  = loop_en ? bus.mosi : model_bit;

  // Event monitor: monotonic counters, tests work on deltas.
  int         n_sptef = 0, n_spif = 0, n_modf = 0, n_sck = 0;
  logic       mon_prev_sck = 1'b0;
  logic [7:0] rx_log[$];
  always @(negedge clk) begin
    if (bus.sptef_set) n_sptef++;
    if (bus.modf_set)  n_modf++;
    if (bus.spif_set) begin
      n_spif++;
      rx_log.push_back(bus.rx_data);
    end
    if (bus.sck !== mon_prev_sck) n_sck++;
    mon_prev_sck = bus.sck;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_wr   = 1'b1;
    step(1);
    bus.tx_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (bus.busy && n < max_cyc) begin
      step(1);
      n++;
    end
    check(name, bus.busy, 0);
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] div;
    logic [7:0] tx;
    logic       loop;
    logic [7:0] pat;
    logic [7:0] exp_rx;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_sptef, b_spif, b_sck, b_modf, b_rx;
    int lat, n, edges;
    logic got, gap_seen, prev;

    // exp_lat = clk edges from the write edge to spif_set: 2 + 17*(baud_div+1)
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 1'b1, 8'h00, 8'hA5, 19};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'h3C, 1'b0, 8'h96, 8'h96, 36};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'd3, 8'h00, 1'b0, 8'h81, 8'h81, 70};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'd0, 8'h5A, 1'b1, 8'h00, 8'h5A, 19};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'd2, 8'h00, 1'b0, 8'h96, 8'h96, 53};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'd0, 8'h00, 1'b0, 8'h6C, 8'h6C, 19};

    rst = 1'b1; spe = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    baud_div = 8'd0; loop_en = 1'b1; m_pat = 8'h00;
    bus.tx_wr = 1'b0; bus.tx_data = 8'h00; bus.ss_in_n = 1'b1;
    step(3);
    check("rst_sck", bus.sck, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_ss_n", bus.ss_n, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_pulses", {bus.sptef_set, bus.spif_set, bus.modf_set}, 0);
    rst = 1'b0;
    spe = 1'b1;

    // Single frames across modes, bit orders and baud rates
    foreach (vecs[i]) begin
      cpol = vecs[i].cpol; cpha = vecs[i].cpha; lsbfe = vecs[i].lsbfe;
      baud_div = vecs[i].div; loop_en = vecs[i].loop; m_pat = vecs[i].pat;
      step(3);
      check($sformatf("v%0d_idle_sck", i), bus.sck, vecs[i].cpol);
      b_sptef = n_sptef; b_spif = n_spif; b_sck = n_sck;
      write_byte(vecs[i].tx);
      lat = 0; got = 1'b0;
      while (!got && lat < 400) begin
        step(1);
        lat++;
        if (bus.spif_set) got = 1'b1;
      end
      check($sformatf("v%0d_spif_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rx_data", i), bus.rx_data, vecs[i].exp_rx);
      wait_idle($sformatf("v%0d_idle_timeout", i), 100);
      check($sformatf("v%0d_sptef_count", i), n_sptef - b_sptef, 1);
      check($sformatf("v%0d_spif_count", i), n_spif - b_spif, 1);
      check($sformatf("v%0d_sck_edges", i), n_sck - b_sck, 16);
      check($sformatf("v%0d_end_sck", i), bus.sck, vecs[i].cpol);
      check($sformatf("v%0d_end_ss_n", i), bus.ss_n, 1);
    end

    // Queued second write mid-frame, third write dropped while buffer is full
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; baud_div = 8'd0; loop_en = 1'b1;
    step(2);
    b_sptef = n_sptef; b_spif = n_spif; b_rx = rx_log.size();
    write_byte(8'h3C);
    step(4);
    write_byte(8'hC3);
    step(4);
    write_byte(8'hFF);
    n = 0; gap_seen = 1'b0;
    while (((n_spif - b_spif) < 2 || bus.busy) && n < 300) begin
      step(1);
      n++;
      if ((n_spif - b_spif) >= 1 && bus.busy && bus.ss_n) gap_seen = 1'b1;
    end
    step(40);
    check("q_sptef_count", n_sptef - b_sptef, 2);
    check("q_spif_count", n_spif - b_spif, 2);
    check("q_gap_seen", gap_seen, 1);
    check("q_rx_log_len", rx_log.size() - b_rx, 2);
    if (rx_log.size() - b_rx >= 2) begin
      check("q_rx_first", rx_log[b_rx], 8'h3C);
      check("q_rx_second", rx_log[b_rx + 1], 8'hC3);
    end
    check("q_final_rx", bus.rx_data, 8'hC3);

    // Mode fault after sck edge 5
    baud_div = 8'd3;
    step(2);
    b_spif = n_spif; b_modf = n_modf;
    write_byte(8'h5A);
    edges = 0; n = 0; prev = bus.sck;
    while (edges < 5 && n < 200) begin
      step(1);
      n++;
      if (bus.sck != prev) edges++;
      prev = bus.sck;
    end
    check("mf_reach_edge5", edges, 5);
    check("mf_sck_before", bus.sck, 1);
    bus.ss_in_n = 1'b0;
    step(1);
    check("mf_modf_set", bus.modf_set, 1);
    check("mf_ss_n", bus.ss_n, 1);
    check("mf_sck_idle", bus.sck, 0);
    check("mf_busy", bus.busy, 0);
    step(1);
    check("mf_single_pulse", bus.modf_set, 0);
    step(3);
    bus.ss_in_n = 1'b1;
    step(2);
    bus.ss_in_n = 1'b0;
    step(1);
    check("mf_rearmed", bus.modf_set, 1);
    bus.ss_in_n = 1'b1;
    step(60);
    check("mf_modf_count", n_modf - b_modf, 2);
    check("mf_no_spif", n_spif - b_spif, 0);
    check("mf_rx_unchanged", bus.rx_data, 8'hC3);
    check("mf_stays_idle", bus.busy, 0);

    // spe=0 abort mid-frame; a write while disabled is ignored
    cpol = 1'b1; baud_div = 8'd0;
    step(2);
    b_spif = n_spif; b_modf = n_modf;
    write_byte(8'h99);
    step(6);
    spe = 1'b0;
    step(1);
    check("spe_ss_n", bus.ss_n, 1);
    check("spe_busy", bus.busy, 0);
    check("spe_sck_idle", bus.sck, 1);
    write_byte(8'h42);
    step(2);
    spe = 1'b1;
    step(40);
    check("spe_no_frame", bus.busy, 0);
    check("spe_no_spif", n_spif - b_spif, 0);
    check("spe_no_modf", n_modf - b_modf, 0);

    // Reset mid-XFER with a byte queued behind the active frame
    write_byte(8'h77);
    write_byte(8'h11);
    step(6);
    check("rst_mid_busy_before", bus.busy, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_mid_sck", bus.sck, 0);
    check("rst_mid_ss_n", bus.ss_n, 1);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_mosi", bus.mosi, 0);
    check("rst_mid_rx_data", bus.rx_data, 0);
    check("rst_mid_pulses", {bus.sptef_set, bus.spif_set, bus.modf_set}, 0);
    b_sptef = n_sptef; b_spif = n_spif;
    step(60);
    check("rst_mid_no_sptef", n_sptef - b_sptef, 0);
    check("rst_mid_no_spif", n_spif - b_spif, 0);
    check("rst_mid_buf_empty", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
